// File: rtl/esc_pwm_ctrl.sv
// Multi-channel ESC PWM generator with UART byte-command parser, per-frame
// throttle slew limiting, arm/disarm gating and a command-loss watchdog.

module esc_pwm_lane #(
  parameter int CW     = 16,
  parameter int MIN_T  = 1000,
  parameter int UNIT_T = 1,
  parameter int SLEW   = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          zero,
  input  logic          arm_eff,
  input  logic [CW-1:0] cnt,
  input  logic [9:0]    tgt,
  output logic [9:0]    thr,
  output logic          pwm
);
  logic [9:0]    base, nxt;
  logic [CW-1:0] width, width_nxt;

  always_comb begin
    base = zero ? 10'd0 : thr;
    nxt  = base;
    if (frame_start) begin
      if (tgt > base)      nxt = (tgt - base > 10'(SLEW)) ? base + 10'(SLEW) : tgt;
      else if (base > tgt) nxt = (base - tgt > 10'(SLEW)) ? base - 10'(SLEW) : tgt;
    end
    // width is frozen for the whole frame so a mid-frame change cannot glitch the pulse
    width_nxt = frame_start ? CW'(MIN_T + int'(nxt) * UNIT_T) : width;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr   <= '0;
      width <= '0;
      pwm   <= 1'b0;
    end else begin
      thr   <= nxt;
      width <= width_nxt;
      pwm   <= arm_eff && (cnt < width_nxt);
    end
  end
endmodule

module esc_pwm_ctrl #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int FRAME_HZ     = 50,
  parameter int NCH          = 4,
  parameter int PULSE_MIN_US = 1000,
  parameter int PULSE_MAX_US = 2000,
  parameter int STEP         = 10,
  parameter int SLEW         = 20,
  parameter int WDOG_FRAMES  = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [NCH-1:0]    pwm_out,
  output logic              armed,
  output logic              wdog_trip,
  output logic              cmd_err,
  output logic              frame_start,
  output logic [NCH*10-1:0] thr_cur
);
  localparam int     THR_MAX     = 1000;
  localparam int     FRAME_TICKS = CLK_HZ / FRAME_HZ;
  localparam int     CW          = $clog2(FRAME_TICKS);
  localparam int     CHW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int     WW          = $clog2(WDOG_FRAMES + 1);
  localparam longint MIN_NUM     = longint'(PULSE_MIN_US) * longint'(CLK_HZ);
  localparam longint UNIT_NUM    = longint'(PULSE_MAX_US - PULSE_MIN_US) * longint'(CLK_HZ);
  localparam int     MIN_T       = int'(MIN_NUM / 64'sd1_000_000);
  localparam int     UNIT_T      = int'(UNIT_NUM / 64'sd1_000_000_000);

  if (UNIT_NUM % 64'sd1_000_000_000 != 0) begin : g_unit_chk
    $error("esc_pwm_ctrl: clocks per throttle unit is not an integer");
  end

  typedef enum logic [1:0] {IDLE, SET_HI, SET_LO} state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt;
  logic [CHW-1:0]         ch, ch_nxt;
  logic [7:0]             hi, hi_nxt;
  logic [15:0]            setval;
  logic [NCH-1:0][9:0]    tgt, tgt_nxt;
  logic [WW-1:0]          wd, wd_nxt;
  logic                   armed_nxt, err_nxt, trip_nxt, zero, lat_armed, arm_eff;

  assign frame_start = (cnt == '0);

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch;
    hi_nxt    = hi;
    armed_nxt = armed;
    tgt_nxt   = tgt;
    err_nxt   = 1'b0;
    zero      = 1'b0;
    wd_nxt    = wd;
    trip_nxt  = wdog_trip;
    setval    = {hi, rx_data};
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data[7]) begin
            if (rx_data[6:0] < 7'(NCH)) begin
              ch_nxt    = rx_data[CHW-1:0];
              state_nxt = SET_HI;
            end else err_nxt = 1'b1;
          end else begin
            case (rx_data)
              8'h01: begin
                if (tgt == '0 && !armed) armed_nxt = 1'b1;
                else err_nxt = 1'b1;
              end
              8'h02: begin
                if (armed)
                  for (int i = 0; i < NCH; i++)
                    tgt_nxt[i] = (tgt[i] >= 10'(THR_MAX - STEP)) ? 10'(THR_MAX) : tgt[i] + 10'(STEP);
              end
              8'h03: begin
                for (int i = 0; i < NCH; i++)
                  tgt_nxt[i] = (tgt[i] <= 10'(STEP)) ? 10'd0 : tgt[i] - 10'(STEP);
              end
              8'h04: begin
                armed_nxt = 1'b0;
                tgt_nxt   = '0;
                zero      = 1'b1;
              end
              default: err_nxt = 1'b1;
            endcase
          end
        end
        SET_HI: begin
          hi_nxt    = rx_data;
          state_nxt = SET_LO;
        end
        SET_LO: begin
          if (armed) tgt_nxt[ch] = (setval > 16'(THR_MAX)) ? 10'(THR_MAX) : setval[9:0];
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      wd_nxt   = '0;
      trip_nxt = 1'b0;
    end else if (!armed) begin
      wd_nxt = '0;
    end else if (frame_start && wd != WW'(WDOG_FRAMES)) begin
      // counter parks at the limit so the failsafe fires once per silence period
      wd_nxt = wd + 1'b1;
      if (wd_nxt == WW'(WDOG_FRAMES)) begin
        trip_nxt = 1'b1;
        tgt_nxt  = '0;
      end
    end
    arm_eff = frame_start ? armed_nxt : lat_armed;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      state     <= IDLE;
      ch        <= '0;
      hi        <= '0;
      tgt       <= '0;
      armed     <= 1'b0;
      lat_armed <= 1'b0;
      wd        <= '0;
      wdog_trip <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      cnt       <= (cnt == CW'(FRAME_TICKS - 1)) ? '0 : cnt + 1'b1;
      state     <= state_nxt;
      ch        <= ch_nxt;
      hi        <= hi_nxt;
      tgt       <= tgt_nxt;
      armed     <= armed_nxt;
      wd        <= wd_nxt;
      wdog_trip <= trip_nxt;
      cmd_err   <= err_nxt;
      if (frame_start) lat_armed <= armed_nxt;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    esc_pwm_lane #(.CW(CW), .MIN_T(MIN_T), .UNIT_T(UNIT_T), .SLEW(SLEW)) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .zero        (zero),
      .arm_eff     (arm_eff),
      .cnt         (cnt),
      .tgt         (tgt_nxt[i]),
      .thr         (thr_cur[i*10 +: 10]),
      .pwm         (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_esc_pwm_ctrl.sv
// Bench: a fast-slew 2-channel instance walks a command table; a 4-channel
// instance with default slew covers frame timing, pulse widths and watchdog.

module tb_esc_pwm_ctrl;
  localparam int FT = 2000;

  logic        clk, rst_n, rx_valid;
  logic [7:0]  rx_data;
  logic [3:0]  pwm;
  logic        armed, trip, err, fs;
  logic [39:0] thr;
  logic [1:0]  pwm_f;
  logic        armed_f, trip_f, err_f, fs_f;
  logic [19:0] thr_f;

  int checks = 0;
  int errors = 0;

  esc_pwm_ctrl #(.CLK_HZ(1_000_000), .FRAME_HZ(500), .NCH(4), .WDOG_FRAMES(6)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pwm_out(pwm), .armed(armed), .wdog_trip(trip), .cmd_err(err),
    .frame_start(fs), .thr_cur(thr));

  esc_pwm_ctrl #(.CLK_HZ(1_000_000), .FRAME_HZ(1000), .NCH(2), .PULSE_MIN_US(0),
                 .PULSE_MAX_US(1000), .STEP(300), .SLEW(1000)) dut_f (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .pwm_out(pwm_f), .armed(armed_f), .wdog_trip(trip_f), .cmd_err(err_f),
    .frame_start(fs_f), .thr_cur(thr_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       err;
    logic       arm;
    int         t0;
    int         t1;
  } vec_t;

  vec_t tbl [25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_fs(input bit fast);
    int n = 0;
    while (!(fast ? fs_f : fs) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL frame_start_wait: got timeout want frame_start");
    end
    tick();
  endtask

  // counts high cycles per channel over one full frame; ends just after the next frame edge
  task automatic measure(output int w0, output int w1, output int w3);
    w0 = 0; w1 = 0; w3 = 0;
    for (int k = 0; k < FT; k++) begin
      if (pwm[0]) w0++;
      if (pwm[1]) w1++;
      if (pwm[3]) w3++;
      tick();
    end
  endtask

  initial begin
    int w0, w1, w3, n, seen;
    rst_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    tbl = '{
      '{8'h02, 1'b0, 1'b0,    0,    0},
      '{8'h03, 1'b0, 1'b0,    0,    0},
      '{8'h01, 1'b0, 1'b1,    0,    0},
      '{8'h01, 1'b1, 1'b1,    0,    0},
      '{8'h02, 1'b0, 1'b1,  300,  300},
      '{8'h02, 1'b0, 1'b1,  600,  600},
      '{8'h02, 1'b0, 1'b1,  900,  900},
      '{8'h02, 1'b0, 1'b1, 1000, 1000},
      '{8'h01, 1'b1, 1'b1, 1000, 1000},
      '{8'h82, 1'b1, 1'b1, 1000, 1000},
      '{8'h03, 1'b0, 1'b1,  700,  700},
      '{8'h80, 1'b0, 1'b1,  700,  700},
      '{8'h07, 1'b0, 1'b1,  700,  700},
      '{8'hFF, 1'b0, 1'b1, 1000,  700},
      '{8'h81, 1'b0, 1'b1, 1000,  700},
      '{8'h00, 1'b0, 1'b1, 1000,  700},
      '{8'h2A, 1'b0, 1'b1, 1000,   42},
      '{8'h03, 1'b0, 1'b1,  700,    0},
      '{8'h55, 1'b1, 1'b1,  700,    0},
      '{8'h04, 1'b0, 1'b0,    0,    0},
      '{8'h80, 1'b0, 1'b0,    0,    0},
      '{8'h01, 1'b0, 1'b0,    0,    0},
      '{8'hF4, 1'b0, 1'b0,    0,    0},
      '{8'h02, 1'b0, 1'b0,    0,    0},
      '{8'h01, 1'b0, 1'b1,    0,    0}
    };

    // command table on the fast-slew instance
    do_reset();
    chk("f_reset_armed", int'(armed_f), 0);
    chk("f_reset_thr", int'(thr_f), 0);
    for (int r = 0; r < 25; r++) begin
      send(tbl[r].b);
      chk($sformatf("row%0d_err", r), int'(err_f), int'(tbl[r].err));
      wait_fs(1'b1);
      chk($sformatf("row%0d_armed", r), int'(armed_f), int'(tbl[r].arm));
      chk($sformatf("row%0d_thr0", r), int'(thr_f[9:0]), tbl[r].t0);
      chk($sformatf("row%0d_thr1", r), int'(thr_f[19:10]), tbl[r].t1);
    end

    // reset state and idle frame timing
    do_reset();
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_armed", int'(armed), 0);
    chk("reset_trip", int'(trip), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_thr", int'(thr), 0);
    chk("reset_fs", int'(fs), 1);
    seen = 0;
    for (int f = 0; f < 3; f++) begin
      tick();
      n = 1;
      while (!fs && n < FT + 10) begin
        if (pwm != 0) seen = 1;
        tick();
        n++;
      end
      chk($sformatf("frame_period%0d", f), n, FT);
    end
    chk("idle_pwm_seen", seen, 0);
    chk("idle_armed", int'(armed), 0);

    // ARM + 5x UP: slew 20,40,50
    do_reset();
    send(8'h01);
    for (int i = 0; i < 5; i++) send(8'h02);
    chk("up_armed", int'(armed), 1);
    wait_fs(1'b0);
    chk("up_thr_f1", int'(thr[9:0]), 20);
    measure(w0, w1, w3);
    chk("up_w0_f1", w0, 1020);
    chk("up_thr_f2", int'(thr[9:0]), 40);
    measure(w0, w1, w3);
    chk("up_w0_f2", w0, 1040);
    chk("up_thr_f3", int'(thr[9:0]), 50);
    measure(w0, w1, w3);
    chk("up_w0_f3", w0, 1050);
    chk("up_w3_f3", w3, 1050);

    // SET ch0 = 1000: ramp +20/frame, other channels at minimum
    do_reset();
    send(8'h01); send(8'h80); send(8'h03); send(8'hE8);
    wait_fs(1'b0);
    chk("set_thr0_f1", int'(thr[9:0]), 20);
    chk("set_thr1_f1", int'(thr[19:10]), 0);
    measure(w0, w1, w3);
    chk("set_w0_f1", w0, 1020);
    chk("set_w1_f1", w1, 1000);
    chk("set_w3_f1", w3, 1000);
    measure(w0, w1, w3);
    chk("set_w0_f2", w0, 1040);
    chk("set_thr0_f3", int'(thr[9:0]), 60);

    // out-of-range channel select
    do_reset();
    send(8'h01);
    send(8'h85);
    chk("badch_err", int'(err), 1);
    tick();
    chk("badch_err_pulse", int'(err), 0);
    send(8'h02);
    chk("badch_up_err", int'(err), 0);
    wait_fs(1'b0);
    chk("badch_up_thr0", int'(thr[9:0]), 10);
    chk("badch_up_thr3", int'(thr[39:30]), 10);

    // watchdog: target 100, silence
    do_reset();
    send(8'h01);
    for (int i = 0; i < 10; i++) send(8'h02);
    for (int f = 0; f < 5; f++) wait_fs(1'b0);
    chk("wd_thr_100", int'(thr[9:0]), 100);
    chk("wd_no_trip", int'(trip), 0);
    wait_fs(1'b0);
    chk("wd_trip", int'(trip), 1);
    chk("wd_armed", int'(armed), 1);
    chk("wd_thr_80", int'(thr[9:0]), 80);
    measure(w0, w1, w3);
    chk("wd_w0", w0, 1080);
    chk("wd_thr_60", int'(thr[9:0]), 60);
    send(8'h03);
    chk("wd_clear", int'(trip), 0);
    chk("wd_clear_armed", int'(armed), 1);

    // DISARM mid-pulse: pulse completes, next frame silent
    do_reset();
    send(8'h01);
    for (int i = 0; i < 5; i++) send(8'h02);
    for (int f = 0; f < 3; f++) wait_fs(1'b0);
    n = 0;
    for (int k = 0; k < FT; k++) begin
      if (pwm[0]) n++;
      if (k == 500) begin rx_data = 8'h04; rx_valid = 1'b1; end
      tick();
      rx_valid = 1'b0;
    end
    chk("dis_w0", n, 1050);
    chk("dis_armed", int'(armed), 0);
    chk("dis_thr", int'(thr), 0);
    measure(w0, w1, w3);
    chk("dis_next_w0", w0, 0);
    chk("dis_next_w3", w3, 0);

    // reset mid-frame abandons partial SET
    do_reset();
    send(8'h01);
    send(8'h02);
    wait_fs(1'b0);
    for (int i = 0; i < 100; i++) tick();
    chk("mrst_pwm_pre", int'(pwm[0]), 1);
    send(8'h80);
    rst_n = 1'b0;
    tick();
    chk("mrst_pwm", int'(pwm), 0);
    chk("mrst_armed", int'(armed), 0);
    rst_n = 1'b1;
    send(8'h01);
    chk("mrst_rearm", int'(armed), 1);
    chk("mrst_err", int'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
